// File: rtl/nes_pad_if.sv
// NES pad reader bus: poll request, pad wires and decoded button results.
// The master side (poll controller plus pad) drives start and nes_data; the
// reader drives the pad clock/latch and the results.
interface nes_pad_if;
  logic       start;
  logic       nes_data;
  logic       nes_clk;
  logic       nes_latch;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;
  logic [7:0] pressed;

  modport master (
    output start, nes_data,
    input  nes_clk, nes_latch, buttons, valid, busy, pressed
  );

  modport slave (
    input  start, nes_data,
    output nes_clk, nes_latch, buttons, valid, busy, pressed
  );
endinterface

// File: rtl/nes_pad_reader.sv
// NES controller reader: on a start strobe in IDLE, pulses the pad latch for
// two half-periods, then clocks out eight serial bits (seven nes_clk high
// pulses), sampling each bit at the end of its low phase. The completed byte
// is published on buttons together with a one-cycle valid pulse.
// Optional feature macro NES_PAD_EDGE_EN: when defined, pressed reports the
// buttons that went from released to pressed on each valid pulse; when
// undefined, pressed is tied to zero.
module nes_pad_reader #(
  parameter int HALF_PERIOD = 150
) (
  input logic     clk,
  input logic     rst_n,
  nes_pad_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  localparam logic [9:0] PHASE_LAST = 10'(HALF_PERIOD - 1);

  state_t     state_reg;
  logic [9:0] phase_reg;
  logic [2:0] bit_reg;
  logic [7:0] shift_reg;
  logic [7:0] buttons_reg;
  logic       nes_clk_reg;
  logic       nes_latch_reg;
  logic       valid_reg;
  logic       busy_reg;
  logic [1:0] sync_reg;

  logic       nes_sync;
  logic       phase_done;
  logic       read_complete;
  logic [7:0] buttons_new;

  assign nes_sync      = sync_reg[1];
  assign phase_done    = (phase_reg == PHASE_LAST);
  // Last cycle of the eighth low phase: the final bit is sampled now.
  assign read_complete = (state_reg == LOW) && phase_done && (bit_reg == 3'd7);
  // Bit 7 is merged in directly so buttons and valid appear in the same cycle.
  assign buttons_new   = {~nes_sync, shift_reg[6:0]};

  // Two-flop synchronizer for the asynchronous pad data; idles released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.nes_data};
    end
  end

  // Read sequencer; every output is registered alongside the state.
  // The latch phase is timed as two half-periods (bit_reg counts them) so the
  // 10-bit phase counter covers the full HALF_PERIOD range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      buttons_reg   <= '0;
      nes_clk_reg   <= 1'b0;
      nes_latch_reg <= 1'b0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          nes_clk_reg   <= 1'b0;
          nes_latch_reg <= 1'b0;
          valid_reg     <= 1'b0;
          busy_reg      <= 1'b0;
          phase_reg     <= '0;
          bit_reg       <= '0;
          if (bus.start) begin
            state_reg     <= LATCH;
            nes_latch_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase_done) begin
            phase_reg <= '0;
            if (bit_reg == 3'd1) begin
              state_reg     <= LOW;
              nes_latch_reg <= 1'b0;
              bit_reg       <= '0;
            end else begin
              bit_reg <= 3'd1;
            end
          end else begin
            phase_reg <= phase_reg + 10'd1;
          end
        end
        LOW: begin
          if (phase_done) begin
            phase_reg          <= '0;
            shift_reg[bit_reg] <= ~nes_sync;
            if (bit_reg == 3'd7) begin
              state_reg   <= DONE;
              buttons_reg <= buttons_new;
              valid_reg   <= 1'b1;
            end else begin
              state_reg   <= HIGH;
              nes_clk_reg <= 1'b1;
            end
          end else begin
            phase_reg <= phase_reg + 10'd1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            phase_reg   <= '0;
            bit_reg     <= bit_reg + 3'd1;
            nes_clk_reg <= 1'b0;
            state_reg   <= LOW;
          end else begin
            phase_reg <= phase_reg + 10'd1;
          end
        end
        DONE: begin
          // A start seen here is dropped: reads only begin from IDLE.
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef NES_PAD_EDGE_EN
  logic [7:0] pressed_reg;

  // Newly pressed buttons, valid only alongside the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_reg <= '0;
    end else if (read_complete) begin
      pressed_reg <= buttons_new & ~buttons_reg;
    end else begin
      pressed_reg <= '0;
    end
  end

  assign bus.pressed = pressed_reg;
`else
  assign bus.pressed = 8'h00;
`endif

  assign bus.nes_clk   = nes_clk_reg;
  assign bus.nes_latch = nes_latch_reg;
  assign bus.buttons   = buttons_reg;
  assign bus.valid     = valid_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader. A behavioural pad (parallel-load
// shift register: loads on latch, advances on each nes_clk rise) answers the
// reader; expected buttons/pressed/timing come from the read protocol rules.
module tb_nes_pad_reader;
  localparam int HP     = 4;
  localparam int LAT    = 17 * HP + 1;
  localparam int HP_L   = 150;
  localparam int LAT_L  = 17 * HP_L + 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nes_pad_if bus ();
  nes_pad_if bus_long ();

  nes_pad_reader #(.HALF_PERIOD(HP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  nes_pad_reader #(.HALF_PERIOD(HP_L)) u_dut_long (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_long.slave)
  );

  // Pad model: active-high button state, serialised active-low.
  logic [7:0] pad_state  = 8'h00;
  logic [7:0] pad_shadow = 8'h00;
  int         pad_idx    = 8;

  always @(posedge bus.nes_latch or posedge bus.nes_clk) begin
    if (bus.nes_latch) begin
      pad_shadow = pad_state;
      pad_idx    = 0;
    end else begin
      pad_idx = pad_idx + 1;
    end
  end

  assign bus.nes_data      = (pad_idx < 8) ? ~pad_shadow[pad_idx[2:0]] : 1'b1;
  assign bus_long.nes_data = 1'b0;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prev_btn = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pressed(input logic [7:0] now_btn, input logic [7:0] old_btn);
`ifdef NES_PAD_EDGE_EN
    return now_btn & ~old_btn;
`else
    return 8'h00 & (now_btn | old_btn);
`endif
  endfunction

  // One complete read with timing/protocol monitoring; cycle n is n clocks
  // after the cycle in which start was sampled.
  task automatic do_read(input logic [7:0] pad, input bit extra);
    int         valid_at   = -1;
    int         valid_cnt  = 0;
    int         latch_cyc  = 0;
    int         clk_pulses = 0;
    int         bad_width  = 0;
    int         overlap    = 0;
    int         hi_run     = 0;
    int         hold_bad   = 0;
    logic       prev_clk   = 1'b0;
    logic       latch_c1   = 1'b0;
    logic       busy_mid   = 1'b0;
    logic [7:0] got_btn    = 8'h00;
    logic [7:0] got_prs    = 8'h00;
    logic [7:0] exp_prs;
    @(negedge clk);
    pad_state = pad;
    bus.start = 1'b1;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(negedge clk);
      bus.start = extra && (n == 10 || n == 68 || n == 69);
      if (n == 1)  latch_c1 = bus.nes_latch;
      if (n == 40) busy_mid = bus.busy;
      if (bus.valid) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = n;
        got_btn = bus.buttons;
        got_prs = bus.pressed;
      end else begin
        if (bus.buttons !== (valid_cnt > 0 ? pad : prev_btn)) hold_bad++;
        if (bus.pressed !== 8'h00) hold_bad++;
      end
      if (bus.nes_latch) latch_cyc++;
      if (bus.nes_latch && bus.nes_clk) overlap++;
      if (bus.nes_clk) begin
        if (!prev_clk) clk_pulses++;
        hi_run++;
      end else begin
        if (prev_clk && hi_run != HP) bad_width++;
        hi_run = 0;
      end
      prev_clk = bus.nes_clk;
    end
    exp_prs = exp_pressed(pad, prev_btn);
    check_val("valid_cycle",  valid_at,   LAT);
    check_val("valid_count",  valid_cnt,  1);
    check_val("buttons",      got_btn,    pad);
    check_val("pressed",      got_prs,    exp_prs);
    check_val("latch_at_c1",  latch_c1,   1);
    check_val("latch_cycles", latch_cyc,  2 * HP);
    check_val("clk_pulses",   clk_pulses, 7);
    check_val("clk_width",    bad_width,  0);
    check_val("clk_latch_ov", overlap,    0);
    check_val("busy_mid",     busy_mid,   1);
    check_val("busy_after",   bus.busy,   0);
    check_val("hold",         hold_bad,   0);
    $display("read pad=%02h extra=%0d -> buttons=%02h pressed=%02h valid@%0d",
             pad, extra, got_btn, got_prs, valid_at);
    prev_btn = pad;
  endtask

  // Abort a read at cycle 30 with reset, then verify no valid follows.
  task automatic reset_mid_read(input logic [7:0] pad);
    int stray = 0;
    @(negedge clk);
    pad_state = pad;
    bus.start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_val("rst_outputs",
              {bus.nes_clk, bus.nes_latch, bus.valid, bus.busy, bus.buttons, bus.pressed},
              32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < LAT + 10; n++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) stray++;
    end
    check_val("rst_no_valid", stray, 0);
    $display("reset mid-read pad=%02h -> stray=%0d", pad, stray);
    prev_btn = 8'h00;
  endtask

  initial begin
    int         valid_at;
    logic [7:0] got_btn;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus_long.start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_state",
              {bus.nes_clk, bus.nes_latch, bus.valid, bus.busy, bus.buttons, bus.pressed},
              32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_read(8'h00, 1'b0);
    do_read(8'h81, 1'b0);
    do_read(8'h00, 1'b0);
    do_read(8'h10, 1'b1);
    do_read(8'h10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_read(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    reset_mid_read(8'($urandom_range(1, 255)));
    do_read(8'($urandom_range(0, 255)), 1'b0);

    // Long half-period instance, pad holding every button down.
    valid_at = -1;
    got_btn  = 8'h00;
    @(negedge clk);
    bus_long.start = 1'b1;
    for (int n = 1; n <= LAT_L + 5; n++) begin
      @(negedge clk);
      bus_long.start = 1'b0;
      if (bus_long.valid && valid_at < 0) begin
        valid_at = n;
        got_btn  = bus_long.buttons;
      end
    end
    check_val("long_valid_cycle", valid_at, LAT_L);
    check_val("long_buttons",     got_btn,  8'hFF);
    $display("long read -> buttons=%02h valid@%0d", got_btn, valid_at);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
